regfile_bus_adapter: RTL and testbench
======================================

// Module: regfile_bus_adapter
// PURPOSE
//  Upstream request stage for the 1R/1W byte-enabled config register file.
//  Accepts PULP-style req/gnt peripheral-bus transactions and drives the RF read/write ports.
//  Returns in-order responses through a small response FIFO with r_ready backpressure.
//  Sits between the cluster peripheral interconnect and the RF; it is the RF's only master.
// PARAMETERS
//  ADDR_WIDTH   5            RF word-address width (2**ADDR_WIDTH registers)
//  DATA_WIDTH   64           RF/bus data width, multiple of 8
//  BUS_AW       32           bus byte-address width
//  BASE_ADDR    32'h0        region base; must be aligned to region size
//  RESP_DEPTH   4            response FIFO entries, power of 2, >=2
// PORTS
//  clk           in   1              clock
//  rst           in   1              synchronous reset, active-high
//  req_i         in   1              bus request
//  gnt_o         out  1              grant (combinational from req_i/FIFO state)
//  add_i         in   BUS_AW         byte address
//  wen_i         in   1              1=read, 0=write
//  be_i          in   DATA_WIDTH/8   byte enables (writes only)
//  wdata_i       in   DATA_WIDTH     write data
//  r_valid_o     out  1              response valid
//  r_ready_i     in   1              response accepted
//  r_rdata_o     out  DATA_WIDTH     read data (0 for writes/errors)
//  r_opc_o       out  1              1=error
//  rf_ReadEnable out  1; rf_ReadAddr out ADDR_WIDTH; rf_ReadData in DATA_WIDTH
//  rf_WriteEnable out 1; rf_WriteAddr out ADDR_WIDTH; rf_WriteData out DATA_WIDTH; rf_WriteBE out DATA_WIDTH/8
// BEHAVIOUR
//  - word index = add_i[ADDR_WIDTH+OFS-1:OFS], OFS=$clog2(DATA_WIDTH/8); low OFS bits ignored.
//  - in_range = add_i[BUS_AW-1:ADDR_WIDTH+OFS] == BASE_ADDR upper bits; else error, no RF access.
//  - gnt_o = req_i && (cnt < RESP_DEPTH || (r_valid_o && r_ready_i)); full+pop same cycle grants.
//  - On grant, read: rf_ReadEnable=1, rf_ReadData (async read) captured into FIFO the same cycle.
//  - On grant, write: rf_WriteEnable=1, rf_WriteBE=be_i, rf_WriteData=wdata_i; RF updates at next edge.
//    A write with be_i==0 is still granted and answered with opc=0. No RF bytes change.
//  - Every granted transaction (read or write, ok or error) pushes exactly one response.
//  - Error response: rdata=0, opc=1. Write response: rdata=0, opc=0 unless error.
//  - Latency: response visible on r_valid_o the cycle after grant (min 1 cycle).
//  - r_valid_o/r_rdata_o/r_opc_o are held stable until r_ready_i. Responses return in grant order.
//  - Read granted the cycle after a write to the same word returns the new data (no hazard logic).
//  - FIFO: rd/wr pointers wrap modulo RESP_DEPTH; cnt tracks 0..RESP_DEPTH; push+pop same cycle keeps cnt.
//  - RF outputs are combinational; all enables are 0 when no grant.
//  - Reset: cnt=0, pointers=0, r_valid_o=0, r_rdata_o=0, r_opc_o=0, lock=0. In-flight responses are dropped.
//    Reset has no effect on RF contents; the RF's own reset clears it.
// CONFIGURATION
//  REGFILE_BUS_ADAPTER_WR_LOCK_EN defined:
//    - Word N-1 (N=2**ADDR_WIDTH) is the lock word; a shadow flop tracks bit0 of writes to it with be_i[0]=1.
//    - While lock=1, writes to words 0..N-2 assert no rf_WriteEnable and respond opc=1; reads are unaffected.
//    - Writes to word N-1 are always performed.
//  Undefined: no lock flop; every in-range write is performed.
// STRUCTURE
//  regfile_adapter_pkg: resp_t {logic [DATA_WIDTH-1:0] rdata; logic opc;} (parametrised via localparam),
//    OPC_OK=1'b0, OPC_ERR=1'b1, WEN_READ=1'b1, WEN_WRITE=1'b0.
//  Sub-module regfile_resp_fifo: depth RESP_DEPTH, push/pop/full/empty/cnt, holds resp_t.
// TESTING
//  1 write add=0x08 be=0xFF wdata=0xDEAD_BEEF_0123_4567, then read 0x08 next cycle -> r_rdata=that value, opc=0, r_valid 1 cycle after each grant.
//  2 write 0x10 be=0x0F wdata=all-ones onto 0 -> read 0x10 returns 0x0000_0000_FFFF_FFFF.
//  3 hold r_ready=0, issue 5 reads (RESP_DEPTH=4) -> 4 grants, 5th gnt=0; r_ready=1 one cycle -> 5th granted that cycle; order preserved.
//  4 read add=BASE+0x400 (out of range, default params) -> opc=1, rdata=0, rf_ReadEnable=0.
//  5 rst pulsed with 3 responses queued -> r_valid=0 the next cycle, cnt=0; new read then answered normally.
//  6 (LOCK_EN) write word 31 be[0]=1 bit0=1, then write word 2 -> opc=1, word 2 unchanged; write word 31 bit0=0 -> word 2 writable.

Source files
------------

// File: rtl/regfile_adapter_pkg.sv
// Shared types and encodings for the register-file bus adapter.
// Response word width follows RF_DW; keep it equal to the adapter DATA_WIDTH.
package regfile_adapter_pkg;

  localparam int RF_DW = 64;

  typedef struct packed {
    logic [RF_DW-1:0] rdata;
    logic             opc;
  } resp_t;

  localparam logic OPC_OK    = 1'b0;
  localparam logic OPC_ERR   = 1'b1;
  localparam logic WEN_READ  = 1'b1;
  localparam logic WEN_WRITE = 1'b0;

endpackage

// File: rtl/regfile_resp_fifo.sv
// In-order response queue; head is presented combinationally, zero when empty.
// Caller guarantees push only with space (or a same-cycle pop) and pop only when non-empty.
module regfile_resp_fifo
  import regfile_adapter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  resp_t                      din,
  output resp_t                      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  resp_t          mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign cnt   = cnt_q;
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/regfile_bus_adapter.sv
// req/gnt peripheral-bus front end for the 1R/1W byte-enabled config RF.
// Optional write lock on the top word: define REGFILE_BUS_ADAPTER_WR_LOCK_EN.
module regfile_bus_adapter
  import regfile_adapter_pkg::*;
#(
  parameter int                ADDR_WIDTH = 5,
  parameter int                DATA_WIDTH = 64,
  parameter int                BUS_AW     = 32,
  parameter logic [BUS_AW-1:0] BASE_ADDR  = '0,
  parameter int                RESP_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [BUS_AW-1:0]       add_i,
  input  logic                    wen_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    r_valid_o,
  input  logic                    r_ready_i,
  output logic [DATA_WIDTH-1:0]   r_rdata_o,
  output logic                    r_opc_o,
  output logic                    rf_ReadEnable,
  output logic [ADDR_WIDTH-1:0]   rf_ReadAddr,
  input  logic [DATA_WIDTH-1:0]   rf_ReadData,
  output logic                    rf_WriteEnable,
  output logic [ADDR_WIDTH-1:0]   rf_WriteAddr,
  output logic [DATA_WIDTH-1:0]   rf_WriteData,
  output logic [DATA_WIDTH/8-1:0] rf_WriteBE
);

  localparam int OFS = $clog2(DATA_WIDTH/8);
  localparam int HI  = ADDR_WIDTH + OFS;
  localparam int CW  = $clog2(RESP_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] word;
  logic                  in_range;
  logic                  is_read;
  logic                  is_write;
  logic                  blocked;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         cnt;
  resp_t                 resp_in;
  resp_t                 resp_out;

  assign word     = add_i[HI-1:OFS];
  assign in_range = (add_i[BUS_AW-1:HI] == BASE_ADDR[BUS_AW-1:HI]);
  assign is_read  = (wen_i == WEN_READ);
  assign is_write = (wen_i == WEN_WRITE);

  // A pop in the same cycle frees a slot, so a full queue can still grant.
  assign pop   = r_valid_o && r_ready_i;
  assign gnt_o = req_i && ((cnt < CW'(RESP_DEPTH)) || pop);

`ifdef REGFILE_BUS_ADAPTER_WR_LOCK_EN
  logic lock;
  logic lock_word;

  assign lock_word = &word;
  assign blocked   = lock && is_write && !lock_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      lock <= 1'b0;
    end else if (gnt_o && is_write && in_range && lock_word && be_i[0]) begin
      lock <= wdata_i[0];
    end
  end
`else
  assign blocked = 1'b0;
`endif

  assign rf_ReadEnable  = gnt_o && is_read && in_range;
  assign rf_ReadAddr    = word;
  assign rf_WriteEnable = gnt_o && is_write && in_range && !blocked;
  assign rf_WriteAddr   = word;
  assign rf_WriteData   = wdata_i;
  assign rf_WriteBE     = be_i;

  assign resp_in.rdata = rf_ReadEnable ? rf_ReadData : '0;
  assign resp_in.opc   = (in_range && !blocked) ? OPC_OK : OPC_ERR;

  regfile_resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_o),
    .pop   (pop),
    .din   (resp_in),
    .dout  (resp_out),
    .full  (full),
    .empty (empty),
    .cnt   (cnt)
  );

  assign r_valid_o = !empty;
  assign r_rdata_o = resp_out.rdata;
  assign r_opc_o   = resp_out.opc;

  logic unused_bits;
  assign unused_bits = ^{add_i[OFS-1:0], full};

endmodule

// File: tb/tb_regfile_bus_adapter.sv
// Bench for regfile_bus_adapter: vector table, response scoreboard, corner sequences.
// Lock sequence runs when REGFILE_BUS_ADAPTER_WR_LOCK_EN is defined.
module tb_regfile_bus_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] add_i;
  logic        wen_i;
  logic [7:0]  be_i;
  logic [63:0] wdata_i;
  logic        r_valid_o;
  logic        r_ready_i;
  logic [63:0] r_rdata_o;
  logic        r_opc_o;
  logic        rf_ReadEnable;
  logic [4:0]  rf_ReadAddr;
  logic [63:0] rf_ReadData;
  logic        rf_WriteEnable;
  logic [4:0]  rf_WriteAddr;
  logic [63:0] rf_WriteData;
  logic [7:0]  rf_WriteBE;

  always #5 clk = ~clk;

  regfile_bus_adapter dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req_i),
    .gnt_o          (gnt_o),
    .add_i          (add_i),
    .wen_i          (wen_i),
    .be_i           (be_i),
    .wdata_i        (wdata_i),
    .r_valid_o      (r_valid_o),
    .r_ready_i      (r_ready_i),
    .r_rdata_o      (r_rdata_o),
    .r_opc_o        (r_opc_o),
    .rf_ReadEnable  (rf_ReadEnable),
    .rf_ReadAddr    (rf_ReadAddr),
    .rf_ReadData    (rf_ReadData),
    .rf_WriteEnable (rf_WriteEnable),
    .rf_WriteAddr   (rf_WriteAddr),
    .rf_WriteData   (rf_WriteData),
    .rf_WriteBE     (rf_WriteBE)
  );

  // Register file the adapter drives: async read, byte-enabled write.
  logic [63:0] rf [32];
  assign rf_ReadData = rf[rf_ReadAddr];
  always @(posedge clk) begin
    if (rf_WriteEnable) begin
      for (int b = 0; b < 8; b++) begin
        if (rf_WriteBE[b]) rf[rf_WriteAddr][b*8 +: 8] <= rf_WriteData[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        opc;
    logic        ren_rf;
    logic        wen_rf;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        opc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && r_valid_o && r_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_resp: got rdata %h with nothing expected", r_rdata_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", r_rdata_o, e.rdata);
        chk("resp_opc", 64'(r_opc_o), 64'(e.opc));
      end
    end
  end

  task automatic apply_vec(input vec_t v);
    exp_t e;
    req_i = 1'b1; add_i = v.add; wen_i = v.wen; be_i = v.be; wdata_i = v.wdata;
    @(negedge clk);
    chk("gnt", 64'(gnt_o), 64'd1);
    chk("rf_ren", 64'(rf_ReadEnable), 64'(v.ren_rf));
    chk("rf_wen", 64'(rf_WriteEnable), 64'(v.wen_rf));
    if (gnt_o) begin
      e.rdata = v.rdata; e.opc = v.opc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_i = 1'b0;
    chk("latency_valid", 64'(r_valid_o), 64'd1);
  endtask

  task automatic drain();
    r_ready_i = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("idle_valid", 64'(r_valid_o), 64'd0);
  endtask

  // Five reads against a stalled consumer; RF content is fixed by the table.
  logic [31:0] bp_add [5] = '{32'h08, 32'h10, 32'h18, 32'hF8, 32'h0C};
  logic [63:0] bp_dat [5] = '{64'hDEAD_BEEF_0123_4567, 64'h0000_0000_FFFF_FFFF,
                              64'h1122_3344_0000_0000, 64'h0, 64'hDEAD_BEEF_0123_4567};

  task automatic push_read(input int i);
    exp_t e;
    e.rdata = bp_dat[i]; e.opc = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic bp_seq();
    r_ready_i = 1'b0;
    wen_i = 1'b1; be_i = '0; wdata_i = '0;
    for (int i = 0; i < 4; i++) begin
      req_i = 1'b1; add_i = bp_add[i];
      @(negedge clk);
      chk("bp_gnt", 64'(gnt_o), 64'd1);
      if (gnt_o) push_read(i);
      @(posedge clk); #1;
    end
    add_i = bp_add[4];
    repeat (2) begin
      @(negedge clk);
      chk("bp_full_gnt", 64'(gnt_o), 64'd0);
      @(posedge clk); #1;
    end
    r_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_full_pop_gnt", 64'(gnt_o), 64'd1);
    if (gnt_o) push_read(4);
    @(posedge clk); #1;
    req_i = 1'b0;
    drain();
  endtask

  vec_t tbl[12];
`ifdef REGFILE_BUS_ADAPTER_WR_LOCK_EN
  vec_t lock_tbl[7];
`endif

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    //         add      wen   be     wdata                  rdata                  opc  ren  wen
    tbl[0]  = '{32'h08,  1'b0, 8'hFF, 64'hDEAD_BEEF_0123_4567, 64'h0,            1'b0, 1'b0, 1'b1};
    tbl[1]  = '{32'h08,  1'b1, 8'h00, 64'h0, 64'hDEAD_BEEF_0123_4567,           1'b0, 1'b1, 1'b0};
    tbl[2]  = '{32'h10,  1'b0, 8'h0F, '1,    64'h0,                             1'b0, 1'b0, 1'b1};
    tbl[3]  = '{32'h10,  1'b1, 8'h00, 64'h0, 64'h0000_0000_FFFF_FFFF,           1'b0, 1'b1, 1'b0};
    tbl[4]  = '{32'h400, 1'b1, 8'h00, 64'h0, 64'h0,                             1'b1, 1'b0, 1'b0};
    tbl[5]  = '{32'h408, 1'b0, 8'hFF, '1,    64'h0,                             1'b1, 1'b0, 1'b0};
    tbl[6]  = '{32'h18,  1'b0, 8'h00, '1,    64'h0,                             1'b0, 1'b0, 1'b1};
    tbl[7]  = '{32'h18,  1'b1, 8'h00, 64'h0, 64'h0,                             1'b0, 1'b1, 1'b0};
    tbl[8]  = '{32'h1D,  1'b0, 8'hF0, 64'h1122_3344_5566_7788, 64'h0,           1'b0, 1'b0, 1'b1};
    tbl[9]  = '{32'h1F,  1'b1, 8'h00, 64'h0, 64'h1122_3344_0000_0000,           1'b0, 1'b1, 1'b0};
    tbl[10] = '{32'hF8,  1'b1, 8'h00, 64'h0, 64'h0,                             1'b0, 1'b1, 1'b0};
    tbl[11] = '{32'h408, 1'b1, 8'h00, 64'h0, 64'h0,                             1'b1, 1'b0, 1'b0};

    rst = 1'b1; req_i = 1'b0; add_i = '0; wen_i = 1'b1; be_i = '0; wdata_i = '0;
    r_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(r_valid_o), 64'd0);
    chk("rst_rdata", r_rdata_o, 64'd0);
    chk("rst_opc", 64'(r_opc_o), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) apply_vec(tbl[i]);
    drain();

    bp_seq();

    r_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_i = 1'b1; add_i = bp_add[i]; wen_i = 1'b1;
      @(negedge clk);
      chk("pre_rst_gnt", 64'(gnt_o), 64'd1);
      @(posedge clk); #1;
    end
    req_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 64'(r_valid_o), 64'd0);
    chk("mid_rst_rdata", r_rdata_o, 64'd0);
    chk("mid_rst_opc", 64'(r_opc_o), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    bp_seq();

`ifdef REGFILE_BUS_ADAPTER_WR_LOCK_EN
    lock_tbl[0] = '{32'hF8, 1'b0, 8'h01, 64'h1, 64'h0,                    1'b0, 1'b0, 1'b1};
    lock_tbl[1] = '{32'h10, 1'b0, 8'hFF, 64'h0, 64'h0,                    1'b1, 1'b0, 1'b0};
    lock_tbl[2] = '{32'h10, 1'b1, 8'h00, 64'h0, 64'h0000_0000_FFFF_FFFF,  1'b0, 1'b1, 1'b0};
    lock_tbl[3] = '{32'hF8, 1'b1, 8'h00, 64'h0, 64'h1,                    1'b0, 1'b1, 1'b0};
    lock_tbl[4] = '{32'hF8, 1'b0, 8'h01, 64'h0, 64'h0,                    1'b0, 1'b0, 1'b1};
    lock_tbl[5] = '{32'h10, 1'b0, 8'hFF, 64'hAB, 64'h0,                   1'b0, 1'b0, 1'b1};
    lock_tbl[6] = '{32'h10, 1'b1, 8'h00, 64'h0, 64'hAB,                   1'b0, 1'b1, 1'b0};
    r_ready_i = 1'b1;
    for (int i = 0; i < 7; i++) apply_vec(lock_tbl[i]);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
